// File: rtl/user_obi_rr_arbiter.sv
// N-to-1 OBI arbiter: round-robin grant with a sticky selection while a request stalls,
// plus an in-order ID FIFO that routes each subordinate response back to its manager.
module user_obi_rr_arbiter #(
    parameter int unsigned NumMgr    = 2,
    parameter int unsigned MaxTrans  = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumMgr-1:0]                     mgr_req_i,
    output logic [NumMgr-1:0]                     mgr_gnt_o,
    input  logic [NumMgr-1:0][AddrWidth-1:0]      mgr_addr_i,
    input  logic [NumMgr-1:0]                     mgr_we_i,
    input  logic [NumMgr-1:0][DataWidth/8-1:0]    mgr_be_i,
    input  logic [NumMgr-1:0][DataWidth-1:0]      mgr_wdata_i,
    output logic [NumMgr-1:0]                     mgr_rvalid_o,
    output logic [DataWidth-1:0]                  mgr_rdata_o,
    output logic                                  mgr_err_o,
    output logic                                  sbr_req_o,
    input  logic                                  sbr_gnt_i,
    output logic [AddrWidth-1:0]                  sbr_addr_o,
    output logic                                  sbr_we_o,
    output logic [DataWidth/8-1:0]                sbr_be_o,
    output logic [DataWidth-1:0]                  sbr_wdata_o,
    input  logic                                  sbr_rvalid_i,
    input  logic [DataWidth-1:0]                  sbr_rdata_i,
    input  logic                                  sbr_err_i
);

    localparam int unsigned IdWidth  = (NumMgr > 1) ? $clog2(NumMgr) : 1;
    localparam int unsigned PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntWidth = $clog2(MaxTrans + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e               state_q, state_d;
    logic [IdWidth-1:0]   sel_q, sel_d;
    logic [IdWidth-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdWidth-1:0]   arb_sel;
    logic [IdWidth-1:0]   sel_c;
    logic [IdWidth-1:0]   id_mem [MaxTrans];
    logic [IdWidth-1:0]   head_id;
    logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]  count_q;
    logic                 fifo_full, fifo_empty;
    logic                 req_sel, accept, push, pop;

    // First requester at or after rr_ptr, wrapping around the manager set
    always_comb begin
        logic                found;
        logic [IdWidth-1:0]  idx;
        arb_sel = rr_ptr_q;
        found   = 1'b0;
        for (int unsigned i = 0; i < NumMgr; i++) begin
            idx = IdWidth'((32'(rr_ptr_q) + i) % NumMgr);
            if (!found && mgr_req_i[idx]) begin
                arb_sel = idx;
                found   = 1'b1;
            end
        end
    end

    assign sel_c      = (state_q == LOCKED) ? sel_q : arb_sel;
    assign fifo_full  = (count_q == CntWidth'(MaxTrans));
    assign fifo_empty = (count_q == '0);
    assign req_sel    = rst_ni && mgr_req_i[sel_c];
    assign accept     = sbr_req_o && sbr_gnt_i;
    assign push       = accept;
    assign pop        = sbr_rvalid_i && !fifo_empty;
    assign head_id    = id_mem[rd_ptr_q];

    // Request forwarding, grant and response routing
    always_comb begin
        sbr_req_o    = req_sel && !fifo_full;
        sbr_addr_o   = '0;
        sbr_we_o     = 1'b0;
        sbr_be_o     = '0;
        sbr_wdata_o  = '0;
        mgr_gnt_o    = '0;
        mgr_rvalid_o = '0;
        mgr_rdata_o  = '0;
        mgr_err_o    = 1'b0;
        if (req_sel) begin
            sbr_addr_o  = mgr_addr_i[sel_c];
            sbr_we_o    = mgr_we_i[sel_c];
            sbr_be_o    = mgr_be_i[sel_c];
            sbr_wdata_o = mgr_wdata_i[sel_c];
        end
        if (accept) begin
            mgr_gnt_o[sel_c] = 1'b1;
        end
        if (pop) begin
            mgr_rvalid_o[head_id] = 1'b1;
            mgr_rdata_o           = sbr_rdata_i;
            mgr_err_o             = sbr_err_i;
        end
    end

    // Lock the selection while a forwarded request waits for its handshake
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (req_sel && !accept) begin
                    state_d = LOCKED;
                    sel_d   = sel_c;
                end
            end
            LOCKED: begin
                if (accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            rr_ptr_d = (sel_c == IdWidth'(NumMgr - 1)) ? '0 : sel_c + IdWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // In-order ID FIFO; fullness uses the registered count so a pop frees a slot next cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrWidth'(MaxTrans - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrWidth'(MaxTrans - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntWidth'(1);
                2'b01:   count_q <= count_q - CntWidth'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr_q] <= sel_c;
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(mgr_gnt_o));

    a_rvalid_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(mgr_rvalid_o));

    a_rvalid_without_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        sbr_rvalid_i |-> !fifo_empty);

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (sbr_req_o && !sbr_gnt_i) |=> (sbr_req_o && $stable(sbr_addr_o) && $stable(sbr_we_o)
                                       && $stable(sbr_be_o) && $stable(sbr_wdata_o)));

endmodule

// File: tb/tb_user_obi_rr_arbiter.sv
// Bench for user_obi_rr_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the arbitration and response routing rules.
module tb_user_obi_rr_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned MT = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N-1:0]           mgr_req;
    logic [N-1:0]           mgr_gnt;
    logic [N-1:0][AW-1:0]   mgr_addr;
    logic [N-1:0]           mgr_we;
    logic [N-1:0][BW-1:0]   mgr_be;
    logic [N-1:0][DW-1:0]   mgr_wdata;
    logic [N-1:0]           mgr_rvalid;
    logic [DW-1:0]          mgr_rdata;
    logic                   mgr_err;
    logic                   sbr_req;
    logic                   sbr_gnt;
    logic [AW-1:0]          sbr_addr;
    logic                   sbr_we;
    logic [BW-1:0]          sbr_be;
    logic [DW-1:0]          sbr_wdata;
    logic                   sbr_rvalid;
    logic [DW-1:0]          sbr_rdata;
    logic                   sbr_err;

    always #5 clk = ~clk;

    user_obi_rr_arbiter #(
        .NumMgr   (N),
        .MaxTrans (MT),
        .AddrWidth(AW),
        .DataWidth(DW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mgr_req_i   (mgr_req),
        .mgr_gnt_o   (mgr_gnt),
        .mgr_addr_i  (mgr_addr),
        .mgr_we_i    (mgr_we),
        .mgr_be_i    (mgr_be),
        .mgr_wdata_i (mgr_wdata),
        .mgr_rvalid_o(mgr_rvalid),
        .mgr_rdata_o (mgr_rdata),
        .mgr_err_o   (mgr_err),
        .sbr_req_o   (sbr_req),
        .sbr_gnt_i   (sbr_gnt),
        .sbr_addr_o  (sbr_addr),
        .sbr_we_o    (sbr_we),
        .sbr_be_o    (sbr_be),
        .sbr_wdata_o (sbr_wdata),
        .sbr_rvalid_i(sbr_rvalid),
        .sbr_rdata_i (sbr_rdata),
        .sbr_err_i   (sbr_err)
    );

    int checks = 0;
    int errors = 0;

    // Manager-side pending requests (held until granted, as OBI requires)
    bit             pend   [N];
    logic [AW-1:0]  p_addr [N];
    logic           p_we   [N];
    logic [BW-1:0]  p_be   [N];
    logic [DW-1:0]  p_wdata[N];

    // Reference model: next-in-line pointer, sticky choice, queue of outstanding owners
    int  m_rr;
    bit  m_lk;
    int  m_sel;
    int  m_q[$];

    int             e_s;
    bit             e_reqs, e_pop;
    logic           e_req;
    logic [N-1:0]   e_gnt, e_rvalid;
    logic [AW-1:0]  e_addr;
    logic           e_we;
    logic [BW-1:0]  e_be;
    logic [DW-1:0]  e_wdata, e_rdata;
    logic           e_err;

    task automatic model_reset();
        m_rr  = 0;
        m_lk  = 1'b0;
        m_sel = 0;
        m_q.delete();
    endtask

    task automatic model_expect();
        bit full;
        full = (m_q.size() == MT);
        e_s  = m_rr;
        if (m_lk) begin
            e_s = m_sel;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (pend[(m_rr + k) % N]) begin
                    e_s = (m_rr + k) % N;
                    break;
                end
            end
        end
        e_reqs   = pend[e_s];
        e_req    = e_reqs && !full;
        e_gnt    = (e_req && sbr_gnt) ? N'(1 << e_s) : '0;
        e_addr   = e_reqs ? p_addr[e_s]  : '0;
        e_we     = e_reqs ? p_we[e_s]    : 1'b0;
        e_be     = e_reqs ? p_be[e_s]    : '0;
        e_wdata  = e_reqs ? p_wdata[e_s] : '0;
        e_pop    = (m_q.size() > 0) && sbr_rvalid;
        e_rvalid = e_pop ? N'(1 << m_q[0]) : '0;
        e_rdata  = e_pop ? sbr_rdata : '0;
        e_err    = e_pop ? sbr_err : 1'b0;
    endtask

    task automatic model_advance();
        if (e_pop) void'(m_q.pop_front());
        if (e_req && sbr_gnt) begin
            m_q.push_back(e_s);
            m_rr      = (e_s + 1) % N;
            m_lk      = 1'b0;
            pend[e_s] = 1'b0;
        end else if (e_reqs) begin
            m_lk  = 1'b1;
            m_sel = e_s;
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            mgr_req[i]   = pend[i];
            mgr_addr[i]  = p_addr[i];
            mgr_we[i]    = p_we[i];
            mgr_be[i]    = p_be[i];
            mgr_wdata[i] = p_wdata[i];
        end
    endtask

    task automatic settle();
        apply();
        #3;
        model_expect();
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic raise(input int i, input logic [AW-1:0] a, input logic we,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd);
        pend[i]    = 1'b1;
        p_addr[i]  = a;
        p_we[i]    = we;
        p_be[i]    = be;
        p_wdata[i] = wd;
    endtask

    task automatic raise_rand(input int i);
        if (!pend[i]) raise(i, $urandom, 1'($urandom_range(0, 1)), BW'($urandom), $urandom);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        sbr_gnt    = 1'b0;
        sbr_rvalid = 1'b0;
        sbr_rdata  = '0;
        sbr_err    = 1'b0;
        apply();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        raise(0, 32'h1000_0000, 1'b1, 4'hF, 32'h1111_1111);
        raise(1, 32'h2000_0000, 1'b0, 4'h3, 32'h2222_2222);
        sbr_gnt    = 1'b1;
        sbr_rvalid = 1'b1;
        sbr_rdata  = 32'hCAFE_F00D;
        sbr_err    = 1'b1;
        apply();
        @(posedge clk);
        #3;
        checks++;
        if (sbr_req !== 1'b0 || mgr_gnt !== '0) begin
            errors++;
            $display("FAIL reset_req got req=%b gnt=%b exp req=0 gnt=0", sbr_req, mgr_gnt);
        end
        checks++;
        if (sbr_addr !== '0 || sbr_wdata !== '0 || sbr_be !== '0 || sbr_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_payload got addr=%h wdata=%h exp 0", sbr_addr, sbr_wdata);
        end
        checks++;
        if (mgr_rvalid !== '0 || mgr_rdata !== '0 || mgr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp got rvalid=%b rdata=%h err=%b exp 0", mgr_rvalid, mgr_rdata, mgr_err);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        raise(0, 32'h2000_1004, 1'b1, 4'hF, 32'hDEAD_BEEF);
        sbr_gnt = 1'b1;
        settle();
        checks++;
        if (sbr_req !== 1'b1 || mgr_gnt !== 2'b01) begin
            errors++;
            $display("FAIL single_gnt got req=%b gnt=%b exp req=1 gnt=01", sbr_req, mgr_gnt);
        end
        checks++;
        if (sbr_addr !== 32'h2000_1004 || sbr_wdata !== 32'hDEAD_BEEF || sbr_we !== 1'b1 || sbr_be !== 4'hF) begin
            errors++;
            $display("FAIL single_payload got addr=%h wdata=%h we=%b be=%h exp 20001004 deadbeef 1 f",
                     sbr_addr, sbr_wdata, sbr_we, sbr_be);
        end
        tick();
        sbr_rvalid = 1'b1;
        sbr_rdata  = 32'h0000_1234;
        settle();
        checks++;
        if (mgr_rvalid !== 2'b01 || mgr_rdata !== 32'h0000_1234) begin
            errors++;
            $display("FAIL single_rsp got rvalid=%b rdata=%h exp 01 00001234", mgr_rvalid, mgr_rdata);
        end
        tick();
        sbr_rvalid = 1'b0;
        raise(0, 32'h0000_0010, 1'b0, 4'hF, 32'h0);
        raise(1, 32'h0000_0020, 1'b0, 4'hF, 32'h0);
        settle();
        checks++;
        if (mgr_gnt !== 2'b10) begin
            errors++;
            $display("FAIL single_rrptr got gnt=%b exp 10", mgr_gnt);
        end
        tick();
        sbr_rvalid = 1'b1;
        settle();
        checks++;
        if (mgr_gnt !== 2'b01 || mgr_rvalid !== 2'b10) begin
            errors++;
            $display("FAIL single_overlap got gnt=%b rvalid=%b exp gnt=01 rvalid=10", mgr_gnt, mgr_rvalid);
        end
        tick();
        settle();
        checks++;
        if (mgr_rvalid !== 2'b01 || mgr_gnt !== 2'b00) begin
            errors++;
            $display("FAIL single_last_rsp got rvalid=%b gnt=%b exp rvalid=01 gnt=00", mgr_rvalid, mgr_gnt);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_g, prev_g;
        do_reset();
        sbr_gnt = 1'b1;
        prev_g  = '0;
        for (int c = 0; c < 8; c++) begin
            raise_rand(0);
            raise_rand(1);
            sbr_rvalid = (c > 0);
            sbr_rdata  = $urandom;
            settle();
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (mgr_gnt !== exp_g) begin
                errors++;
                $display("FAIL contention_gnt c=%0d got %b exp %b", c, mgr_gnt, exp_g);
            end
            if (c > 0) begin
                checks++;
                if (mgr_rvalid !== prev_g || mgr_rdata !== sbr_rdata) begin
                    errors++;
                    $display("FAIL contention_rsp c=%0d got %b exp %b", c, mgr_rvalid, prev_g);
                end
            end
            prev_g = exp_g;
            tick();
        end
        clear_inputs();
        sbr_rvalid = 1'b1;
        settle();
        checks++;
        if (mgr_rvalid !== prev_g) begin
            errors++;
            $display("FAIL contention_drain got %b exp %b", mgr_rvalid, prev_g);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_stall_lock();
        do_reset();
        sbr_gnt = 1'b0;
        raise(1, 32'hA1A1_0004, 1'b1, 4'hC, 32'h1111_0001);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) raise(0, 32'hA0A0_0008, 1'b0, 4'hF, 32'h0);
            settle();
            checks++;
            if (sbr_req !== 1'b1 || sbr_addr !== 32'hA1A1_0004 || mgr_gnt !== 2'b00) begin
                errors++;
                $display("FAIL stall_hold c=%0d got req=%b addr=%h gnt=%b exp 1 a1a10004 00",
                         c, sbr_req, sbr_addr, mgr_gnt);
            end
            tick();
        end
        sbr_gnt = 1'b1;
        settle();
        checks++;
        if (mgr_gnt !== 2'b10 || sbr_wdata !== 32'h1111_0001) begin
            errors++;
            $display("FAIL stall_release got gnt=%b wdata=%h exp 10 11110001", mgr_gnt, sbr_wdata);
        end
        tick();
        settle();
        checks++;
        if (mgr_gnt !== 2'b01 || sbr_addr !== 32'hA0A0_0008) begin
            errors++;
            $display("FAIL stall_next got gnt=%b addr=%h exp 01 a0a00008", mgr_gnt, sbr_addr);
        end
        tick();
        sbr_gnt    = 1'b0;
        sbr_rvalid = 1'b1;
        settle();
        checks++;
        if (mgr_rvalid !== 2'b10) begin
            errors++;
            $display("FAIL stall_rsp0 got %b exp 10", mgr_rvalid);
        end
        tick();
        settle();
        checks++;
        if (mgr_rvalid !== 2'b01) begin
            errors++;
            $display("FAIL stall_rsp1 got %b exp 01", mgr_rvalid);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_backpressure();
        int acc;
        logic [N-1:0] exp_g;
        do_reset();
        sbr_gnt = 1'b1;
        acc     = 0;
        for (int c = 0; c < 5; c++) begin
            raise_rand(0);
            settle();
            if (mgr_gnt[0]) acc++;
            exp_g = (c < 2) ? 2'b01 : 2'b00;
            checks++;
            if (mgr_gnt !== exp_g || sbr_req !== (c < 2)) begin
                errors++;
                $display("FAIL bp_gnt c=%0d got gnt=%b req=%b exp %b", c, mgr_gnt, sbr_req, exp_g);
            end
            tick();
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL bp_accepts got %0d exp 2", acc);
        end
        sbr_rvalid = 1'b1;
        settle();
        checks++;
        if (mgr_rvalid !== 2'b01 || mgr_gnt !== 2'b00) begin
            errors++;
            $display("FAIL bp_pop_same_cycle got rvalid=%b gnt=%b exp 01 00", mgr_rvalid, mgr_gnt);
        end
        tick();
        sbr_rvalid = 1'b0;
        settle();
        checks++;
        if (mgr_gnt !== 2'b01) begin
            errors++;
            $display("FAIL bp_after_pop got gnt=%b exp 01", mgr_gnt);
        end
        tick();
        sbr_gnt    = 1'b0;
        sbr_rvalid = 1'b1;
        repeat (2) begin
            settle();
            checks++;
            if (mgr_rvalid !== 2'b01) begin
                errors++;
                $display("FAIL bp_drain got %b exp 01", mgr_rvalid);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_error();
        do_reset();
        raise(1, 32'h2000_2000, 1'b0, 4'hF, 32'h0);
        sbr_gnt = 1'b1;
        settle();
        checks++;
        if (mgr_gnt !== 2'b10 || sbr_we !== 1'b0 || sbr_addr !== 32'h2000_2000) begin
            errors++;
            $display("FAIL err_req got gnt=%b we=%b addr=%h exp 10 0 20002000", mgr_gnt, sbr_we, sbr_addr);
        end
        tick();
        sbr_rvalid = 1'b1;
        sbr_err    = 1'b1;
        sbr_rdata  = 32'hBAD0_0BAD;
        settle();
        checks++;
        if (mgr_rvalid !== 2'b10 || mgr_err !== 1'b1 || mgr_rdata !== 32'hBAD0_0BAD) begin
            errors++;
            $display("FAIL err_rsp got rvalid=%b err=%b rdata=%h exp 10 1 bad00bad", mgr_rvalid, mgr_err, mgr_rdata);
        end
        tick();
        sbr_rvalid = 1'b0;
        sbr_err    = 1'b0;
        raise(0, 32'h10, 1'b1, 4'h1, 32'h5);
        raise(1, 32'h20, 1'b1, 4'h2, 32'h6);
        settle();
        checks++;
        if (mgr_gnt !== 2'b01) begin
            errors++;
            $display("FAIL err_after0 got gnt=%b exp 01", mgr_gnt);
        end
        tick();
        settle();
        checks++;
        if (mgr_gnt !== 2'b10) begin
            errors++;
            $display("FAIL err_fifo_empty got gnt=%b exp 10", mgr_gnt);
        end
        tick();
        sbr_gnt    = 1'b0;
        sbr_rvalid = 1'b1;
        repeat (2) begin
            settle();
            checks++;
            if (mgr_rvalid !== e_rvalid) begin
                errors++;
                $display("FAIL err_drain got %b exp %b", mgr_rvalid, e_rvalid);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        sbr_gnt = 1'b1;
        repeat (2) begin
            raise_rand(0);
            settle();
            tick();
        end
        raise(1, 32'h3000_0000, 1'b0, 4'hF, 32'h0);
        settle();
        checks++;
        if (mgr_gnt !== 2'b00 || sbr_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_full got gnt=%b req=%b exp 00 0", mgr_gnt, sbr_req);
        end
        tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if (sbr_req !== 1'b0 || mgr_gnt !== 2'b00 || mgr_rvalid !== 2'b00 || sbr_addr !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got req=%b gnt=%b rvalid=%b addr=%h exp 0",
                     sbr_req, mgr_gnt, mgr_rvalid, sbr_addr);
        end
        do_reset();
        sbr_gnt = 1'b1;
        raise_rand(0);
        raise_rand(1);
        settle();
        checks++;
        if (mgr_gnt !== 2'b01) begin
            errors++;
            $display("FAIL mid_restart got gnt=%b exp 01", mgr_gnt);
        end
        tick();
        settle();
        checks++;
        if (mgr_gnt !== 2'b10) begin
            errors++;
            $display("FAIL mid_count_cleared got gnt=%b exp 10", mgr_gnt);
        end
        tick();
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 99) < 60) raise_rand(i);
            end
            sbr_gnt    = ($urandom_range(0, 3) != 0);
            sbr_rvalid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            sbr_rdata  = $urandom;
            sbr_err    = 1'($urandom_range(0, 1));
            settle();
            checks++;
            if (mgr_gnt !== e_gnt || sbr_req !== e_req) begin
                errors++;
                $display("FAIL rand_gnt c=%0d got gnt=%b req=%b exp gnt=%b req=%b", c, mgr_gnt, sbr_req, e_gnt, e_req);
            end
            checks++;
            if (sbr_addr !== e_addr || sbr_we !== e_we || sbr_be !== e_be || sbr_wdata !== e_wdata) begin
                errors++;
                $display("FAIL rand_payload c=%0d got addr=%h wdata=%h exp addr=%h wdata=%h",
                         c, sbr_addr, sbr_wdata, e_addr, e_wdata);
            end
            checks++;
            if (mgr_rvalid !== e_rvalid || mgr_rdata !== e_rdata || mgr_err !== e_err) begin
                errors++;
                $display("FAIL rand_rsp c=%0d got rvalid=%b rdata=%h err=%b exp rvalid=%b rdata=%h err=%b",
                         c, mgr_rvalid, mgr_rdata, mgr_err, e_rvalid, e_rdata, e_err);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) raise(i, '0, 1'b0, '0, '0);
        clear_inputs();
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_stall_lock();
        test_backpressure();
        test_error();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
